// File: rtl/main_memory.sv
// Line-granular main memory model for a cache refill path.
// Serves one line read or write at a time, with a fixed response latency.
// Responses use a valid/ready handshake. Indices past DEPTH return an error
// and never touch the array.
module main_memory #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [LINE_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int OFF    = $clog2(LINE_W / 8);
  localparam int IDX_W  = ADDR_W - OFF;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The extra top bit keeps the range compare unsigned and overflow-free.
  localparam logic [IDX_W:0] DEPTH_EXT = (IDX_W + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q,   state_d;
  logic [3:0]        cnt_q,     cnt_d;
  logic              we_q,      we_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic              inRange_q, inRange_d;
  logic [LINE_W-1:0] wdata_q,   wdata_d;
  logic [LINE_W-1:0] rdata_q,   rdata_d;
  logic              err_q,     err_d;

  logic [LINE_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  reqIdx;
  logic              reqInRange;
  logic [MEM_AW-1:0] memAddr;
  logic              commit;
  logic              unusedBits;

  assign reqIdx     = req_addr[ADDR_W-1:OFF];
  assign reqInRange = ({1'b0, reqIdx} < DEPTH_EXT);
  assign memAddr    = idx_q[MEM_AW-1:0];
  assign commit     = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  assign unusedBits = ^{req_addr[OFF-1:0], idx_q};

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Next-state logic: accept in IDLE, count down in BUSY, hold the response in RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    idx_d     = idx_q;
    inRange_d = inRange_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d   = ST_BUSY;
          cnt_d     = 4'(LATENCY - 1);
          we_d      = req_we;
          idx_d     = reqIdx;
          inRange_d = reqInRange;
          wdata_d   = req_wdata;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          err_d   = !inRange_q;
          rdata_d = (!we_q && inRange_q) ? mem[memAddr] : '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and response registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      inRange_q <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      idx_q     <= idx_d;
      inRange_q <= inRange_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Line array commits writes on the BUSY->RESP edge and is never cleared by reset.
  always_ff @(posedge clk) begin
    if (commit && we_q && inRange_q) begin
      mem[memAddr] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: two instances (LATENCY 4 and 1),
// directed scenarios plus random traffic checked against a line-level model.
module tb_main_memory;

  localparam int LW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          reqValid  [2];
  logic          reqWe     [2];
  logic [31:0]   reqAddr   [2];
  logic [LW-1:0] reqWdata  [2];
  logic          respReady [2];
  logic          reqReady  [2];
  logic          respValid [2];
  logic          respErr   [2];
  logic [LW-1:0] respRdata [2];

  int errors = 0;
  int checks = 0;
  int latOf [2] = '{4, 1};

  // Expected line contents, keyed by instance*1024 + line index.
  logic [LW-1:0] modelMem [int];

  main_memory #(.ADDR_W(32), .LINE_W(LW), .DEPTH(256), .LATENCY(4)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
    .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
    .resp_valid(respValid[0]), .resp_ready(respReady[0]),
    .resp_rdata(respRdata[0]), .resp_err(respErr[0])
  );

  main_memory #(.ADDR_W(32), .LINE_W(LW), .DEPTH(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
    .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
    .resp_valid(respValid[1]), .resp_ready(respReady[1]),
    .resp_rdata(respRdata[1]), .resp_err(respErr[1])
  );

  // Advance to just after the next rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Count one comparison and report it if it does not hold.
  task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                             input logic [LW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Run one complete transaction on instance d and check it against the model.
  task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr,
                               input logic [LW-1:0] wdata, input int hold, input string tag);
    int            idx;
    int            key;
    int            n;
    bit            inRange;
    bit            known;
    logic [LW-1:0] expRdata;
    logic [LW-1:0] heldData;
    logic          heldErr;
    idx      = int'(addr >> 4);
    inRange  = (idx < 256);
    key      = d * 1024 + idx;
    expRdata = '0;
    known    = we || !inRange;
    if (!we && inRange && modelMem.exists(key)) begin
      known    = 1'b1;
      expRdata = modelMem[key];
    end
    reqValid[d] = 1'b1;
    reqWe[d]    = we;
    reqAddr[d]  = addr;
    reqWdata[d] = wdata;
    n = 0;
    while (!reqReady[d] && n < 50) begin
      step;
      n++;
    end
    if (!reqReady[d]) begin
      checkOutput({tag, " accept timeout"}, 0, 1);
      reqValid[d] = 1'b0;
      return;
    end
    step;
    reqValid[d] = 1'b0;
    reqWe[d]    = 1'b0;
    reqWdata[d] = {$urandom, $urandom, $urandom, $urandom};
    checkOutput({tag, " req_ready after accept"}, reqReady[d], 0);
    n = 0;
    while (!respValid[d] && n < 40) begin
      step;
      n++;
    end
    checkOutput({tag, " latency"}, n, latOf[d]);
    if (!respValid[d]) begin
      return;
    end
    checkOutput({tag, " err"}, respErr[d], !inRange);
    if (known) begin
      checkOutput({tag, " rdata"}, respRdata[d], expRdata);
    end
    heldData = respRdata[d];
    heldErr  = respErr[d];
    for (int i = 0; i < hold; i++) begin
      step;
      checkOutput({tag, " hold valid"}, respValid[d], 1);
      checkOutput({tag, " hold rdata"}, respRdata[d], heldData);
      checkOutput({tag, " hold err"}, respErr[d], heldErr);
      checkOutput({tag, " hold req_ready"}, reqReady[d], 0);
    end
    respReady[d] = 1'b1;
    step;
    respReady[d] = 1'b0;
    checkOutput({tag, " resp_valid after handshake"}, respValid[d], 0);
    checkOutput({tag, " req_ready after handshake"}, reqReady[d], 1);
    if (we && inRange) begin
      modelMem[key] = wdata;
    end
  endtask

  initial begin
    int            lastAcc;
    int            nAcc;
    int            n;
    int            idx;
    logic [LW-1:0] lineA;
    logic [31:0]   addr;

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      reqValid[d]  = 1'b0;
      reqWe[d]     = 1'b0;
      reqAddr[d]   = '0;
      reqWdata[d]  = '0;
      respReady[d] = 1'b0;
    end
    repeat (3) step;
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset req_ready", reqReady[d], 1);
      checkOutput("reset resp_valid", respValid[d], 0);
      checkOutput("reset resp_err", respErr[d], 0);
      checkOutput("reset resp_rdata", respRdata[d], 0);
    end
    rst = 1'b1;

    // Write then read the same line through a different byte offset.
    for (int d = 0; d < 2; d++) begin
      applyStimulus(d, 1'b1, 32'h40, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 0, "wr40");
      applyStimulus(d, 1'b0, 32'h4C, '0, 0, "rd4c");
    end

    // Backpressure on a pending read.
    for (int d = 0; d < 2; d++) begin
      applyStimulus(d, 1'b0, 32'h40, '0, 5, "backpressure");
    end

    // Out-of-range read and write must not alias onto line 0.
    for (int d = 0; d < 2; d++) begin
      applyStimulus(d, 1'b1, 32'h0, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 0, "wr0");
      applyStimulus(d, 1'b0, 32'h1000, '0, 0, "oor read");
      applyStimulus(d, 1'b1, 32'h1000, {$urandom, $urandom, $urandom, $urandom}, 0, "oor write");
      applyStimulus(d, 1'b0, 32'h0, '0, 0, "rd0 after oor");
    end

    // Reset during BUSY aborts a write before it commits.
    lineA = 128'hFEED_FACE_0BAD_F00D_1234_5678_9ABC_DEF0;
    applyStimulus(0, 1'b1, 32'h80, lineA, 0, "wr80");
    checkOutput("abort idle before accept", reqReady[0], 1);
    reqValid[0] = 1'b1;
    reqWe[0]    = 1'b1;
    reqAddr[0]  = 32'h80;
    reqWdata[0] = ~lineA;
    step;
    reqValid[0] = 1'b0;
    reqWe[0]    = 1'b0;
    step;
    step;
    rst = 1'b0;
    #1;
    checkOutput("abort resp_valid", respValid[0], 0);
    checkOutput("abort req_ready", reqReady[0], 1);
    checkOutput("abort resp_err", respErr[0], 0);
    checkOutput("abort resp_rdata", respRdata[0], 0);
    step;
    rst = 1'b1;
    applyStimulus(0, 1'b0, 32'h80, '0, 0, "rd80 after abort");

    // Request held high: one accept per IDLE visit, spaced LATENCY+2 cycles.
    for (int d = 0; d < 2; d++) begin
      reqValid[d]  = 1'b1;
      reqWe[d]     = 1'b0;
      reqAddr[d]   = 32'h44;
      respReady[d] = 1'b1;
      lastAcc = -1;
      nAcc    = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
        if (reqReady[d]) begin
          if (lastAcc >= 0) begin
            checkOutput("held spacing", cyc - lastAcc, latOf[d] + 2);
          end
          lastAcc = cyc;
          nAcc++;
        end
        if (respValid[d]) begin
          checkOutput("held rdata", respRdata[d], modelMem[d * 1024 + 4]);
          checkOutput("held err", respErr[d], 0);
        end
        step;
      end
      reqValid[d] = 1'b0;
      checkOutput("held accept count", nAcc, (20 + latOf[d] + 1) / (latOf[d] + 2));
      n = 0;
      while (!reqReady[d] && n < 40) begin
        step;
        n++;
      end
      checkOutput("held drain", reqReady[d], 1);
      respReady[d] = 1'b0;
    end

    // Random traffic on a small set of lines plus occasional out-of-range indices.
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 40; t++) begin
        if ($urandom_range(0, 5) == 0) idx = 256 + int'($urandom_range(0, 40));
        else                           idx = int'($urandom_range(0, 15));
        addr = (32'(idx) << 4) | 32'($urandom_range(0, 15));
        applyStimulus(d, 1'($urandom_range(0, 1)), addr,
                      {$urandom, $urandom, $urandom, $urandom},
                      int'($urandom_range(0, 3)), "random");
      end
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
